// File: rtl/rv32_pkg.sv
// rv32_pkg: shared opcodes, funct fields, decode enums and RAM geometry for rv32_core.
package rv32_pkg;
  localparam int RAM_DEPTH = 4096;
  localparam int AW = 12;
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6F, OP_JALR = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63, OP_LOAD = 7'h03, OP_STORE = 7'h23;
  localparam logic [6:0] OP_IMM = 7'h13, OP_REG = 7'h33;
  localparam logic [2:0] F3_ADD = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR = 3'd4, F3_SR = 3'd5, F3_OR = 3'd6, F3_AND = 3'd7;
  localparam logic [2:0] F3_BEQ = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4, F3_BGE = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6, F3_BGEU = 3'd7;
  localparam logic [2:0] F3_B = 3'd0, F3_H = 3'd1, F3_W = 3'd2, F3_BU = 3'd4, F3_HU = 3'd5;
  localparam logic [6:0] F7_BASE = 7'h00, F7_ALT = 7'h20;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_t;
  function automatic logic [31:0] imm_of(input logic [31:7] i, input imm_t s);
    case (s)
      IMM_S: return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U: return {i[31:12], 12'b0};
      IMM_J: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return {{20{i[31]}}, i[31:20]};
    endcase
  endfunction
endpackage

// File: rtl/rv32_dpram.sv
// rv32_dpram: 4096x32 RAM, combinational-read port 1 and registered byte-enable port 2.
// On a same-cycle collision the port-2 byte lanes override port 1.
module rv32_dpram
  import rv32_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] a1,
  input  logic [31:0]   wd1,
  input  logic [3:0]    we1,
  output logic [31:0]   rd1,
  input  logic [AW-1:0] a2,
  input  logic [31:0]   wd2,
  input  logic [3:0]    we2,
  output logic [31:0]   rd2
);
  logic [31:0] mem [RAM_DEPTH];
  assign rd1 = mem[a1];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++) begin
      if (we1[i]) mem[a1][8*i +: 8] <= wd1[8*i +: 8];
      if (we2[i]) mem[a2][8*i +: 8] <= wd2[8*i +: 8];
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rd2 <= '0;
    else rd2 <= mem[a2];
endmodule

// File: rtl/rv32_core.sv
// rv32_core: single-cycle RV32I core with debug-loadable instruction and data RAMs.
// Define RV32_SUBWORD_MEM_EN to add LB/LH/LBU/LHU/SB/SH.
module rv32_core
  import rv32_pkg::*;
(
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  input  logic [31:0] CPU_Debug_DataRAM_A2,
  input  logic [31:0] CPU_Debug_DataRAM_WD2,
  input  logic [3:0]  CPU_Debug_DataRAM_WE2,
  output logic [31:0] CPU_Debug_DataRAM_RD2,
  input  logic [31:0] CPU_Debug_InstRAM_A2,
  input  logic [31:0] CPU_Debug_InstRAM_WD2,
  input  logic [3:0]  CPU_Debug_InstRAM_WE2,
  output logic [31:0] CPU_Debug_InstRAM_RD2
);
  logic [31:0] pc, pc_next, inst, rs1v, rs2v, imm, b, alu, ld, wd, wb, rd1;
  logic [31:0] rf [32];
  logic [6:0] opc, f7;
  logic [4:0] rs1, rs2, rd;
  logic [2:0] f3;
  imm_t isel;
  alu_op_t aop;
  logic reg_we, taken, ld_ok;
  logic [3:0] mwe, st_mask;
  assign {f7, rs2, rs1, f3, rd, opc} = inst;
  assign rs1v = rf[rs1];
  assign rs2v = rf[rs2];
  assign isel = (opc == OP_LUI || opc == OP_AUIPC) ? IMM_U :
                opc == OP_JAL ? IMM_J : opc == OP_BRANCH ? IMM_B :
                opc == OP_STORE ? IMM_S : IMM_I;
  assign imm = imm_of(inst[31:7], isel);
  assign b = opc == OP_REG ? rs2v : imm;
  always_comb begin
    aop = ALU_ADD;
    if (opc == OP_IMM || opc == OP_REG)
      case (f3)
        F3_ADD:  aop = (opc == OP_REG && f7[5]) ? ALU_SUB : ALU_ADD;
        F3_SLL:  aop = ALU_SLL;
        F3_SLT:  aop = ALU_SLT;
        F3_SLTU: aop = ALU_SLTU;
        F3_XOR:  aop = ALU_XOR;
        F3_SR:   aop = f7[5] ? ALU_SRA : ALU_SRL;
        F3_OR:   aop = ALU_OR;
        default: aop = ALU_AND;
      endcase
  end
  always_comb begin
    case (aop)
      ALU_SUB:  alu = rs1v - b;
      ALU_SLL:  alu = rs1v << b[4:0];
      ALU_SLT:  alu = {31'b0, $signed(rs1v) < $signed(b)};
      ALU_SLTU: alu = {31'b0, rs1v < b};
      ALU_XOR:  alu = rs1v ^ b;
      ALU_SRL:  alu = rs1v >> b[4:0];
      ALU_SRA:  alu = $signed(rs1v) >>> b[4:0];
      ALU_OR:   alu = rs1v | b;
      ALU_AND:  alu = rs1v & b;
      default:  alu = rs1v + b;
    endcase
  end
  always_comb begin
    case (f3)
      F3_BEQ:  taken = rs1v == rs2v;
      F3_BNE:  taken = rs1v != rs2v;
      F3_BLT:  taken = $signed(rs1v) < $signed(rs2v);
      F3_BGE:  taken = $signed(rs1v) >= $signed(rs2v);
      F3_BLTU: taken = rs1v < rs2v;
      F3_BGEU: taken = rs1v >= rs2v;
      default: taken = 1'b0;
    endcase
  end
`ifdef RV32_SUBWORD_MEM_EN
  logic [31:0] ldw;
  logic unused_ld;
  assign ldw = rd1 >> {alu[1:0], 3'b000};
  assign unused_ld = &{1'b0, ldw[31:16]};
  assign ld = f3 == F3_B ? {{24{ldw[7]}}, ldw[7:0]} : f3 == F3_H ? {{16{ldw[15]}}, ldw[15:0]} :
              f3 == F3_BU ? {24'b0, ldw[7:0]} : f3 == F3_HU ? {16'b0, ldw[15:0]} : rd1;
  assign ld_ok = f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU;
  assign st_mask = f3 == F3_B ? 4'b0001 << alu[1:0] : f3 == F3_H ? 4'b0011 << {alu[1], 1'b0} :
                   f3 == F3_W ? 4'hF : 4'h0;
  assign wd = f3 == F3_B ? {4{rs2v[7:0]}} : f3 == F3_H ? {2{rs2v[15:0]}} : rs2v;
`else
  assign ld = rd1;
  assign ld_ok = f3 == F3_W;
  assign st_mask = f3 == F3_W ? 4'hF : 4'h0;
  assign wd = rs2v;
`endif
  always_comb begin
    reg_we = 1'b0;
    mwe = 4'h0;
    wb = alu;
    pc_next = pc + 32'd4;
    case (opc)
      OP_LUI:    begin reg_we = 1'b1; wb = imm; end
      OP_AUIPC:  begin reg_we = 1'b1; wb = pc + imm; end
      OP_JAL:    begin reg_we = 1'b1; wb = pc + 32'd4; pc_next = pc + imm; end
      OP_JALR:   if (f3 == 3'd0) begin reg_we = 1'b1; wb = pc + 32'd4; pc_next = alu; end
      OP_BRANCH: pc_next = taken ? pc + imm : pc + 32'd4;
      OP_LOAD:   begin reg_we = ld_ok; wb = ld; end
      OP_STORE:  mwe = st_mask;
      OP_IMM:    reg_we = (f3 != F3_SLL && f3 != F3_SR) || f7 == F7_BASE || (f3 == F3_SR && f7 == F7_ALT);
      OP_REG:    reg_we = f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR));
      default:   reg_we = 1'b0;
    endcase
  end
  always_ff @(posedge CPU_CLK or negedge CPU_RST)
    if (!CPU_RST) begin
      pc <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      pc <= {pc_next[31:2], 2'b00};
      if (reg_we && rd != 5'd0) rf[rd] <= wb;
    end
  rv32_dpram u_iram (
    .clk(CPU_CLK), .rst_n(CPU_RST),
    .a1(pc[13:2]), .wd1(32'd0), .we1(4'h0), .rd1(inst),
    .a2(CPU_Debug_InstRAM_A2[13:2]), .wd2(CPU_Debug_InstRAM_WD2),
    .we2(CPU_Debug_InstRAM_WE2), .rd2(CPU_Debug_InstRAM_RD2)
  );
  // Reset suppresses core stores while leaving the debug port live.
  rv32_dpram u_dram (
    .clk(CPU_CLK), .rst_n(CPU_RST),
    .a1(alu[13:2]), .wd1(wd), .we1(mwe & {4{CPU_RST}}), .rd1(rd1),
    .a2(CPU_Debug_DataRAM_A2[13:2]), .wd2(CPU_Debug_DataRAM_WD2),
    .we2(CPU_Debug_DataRAM_WE2), .rd2(CPU_Debug_DataRAM_RD2)
  );
  logic unused;
  assign unused = &{1'b0, CPU_Debug_DataRAM_A2[31:14], CPU_Debug_DataRAM_A2[1:0],
                    CPU_Debug_InstRAM_A2[31:14], CPU_Debug_InstRAM_A2[1:0], pc_next[1:0]};
endmodule

// File: tb/tb_rv32_core.sv
// tb_rv32_core: directed programs loaded through the debug ports; results read back
// through data-RAM port 2 and checked by a scoreboard monitor.
module tb_rv32_core;
  logic clk = 0, rst_n = 0;
  logic [31:0] d_a2 = 0, d_wd = 0, i_a2 = 0, i_wd = 0, d_rd, i_rd;
  logic [3:0] d_we = 0, i_we = 0;
  always #5 clk = ~clk;

  rv32_core dut (
    .CPU_CLK(clk), .CPU_RST(rst_n),
    .CPU_Debug_DataRAM_A2(d_a2), .CPU_Debug_DataRAM_WD2(d_wd),
    .CPU_Debug_DataRAM_WE2(d_we), .CPU_Debug_DataRAM_RD2(d_rd),
    .CPU_Debug_InstRAM_A2(i_a2), .CPU_Debug_InstRAM_WD2(i_wd),
    .CPU_Debug_InstRAM_WE2(i_we), .CPU_Debug_InstRAM_RD2(i_rd)
  );

  typedef struct { string name; bit inst; logic [31:0] exp; } exp_t;
  exp_t sb[$];
  exp_t e;
  logic [31:0] got;
  logic [31:0] prog[$];
  int checks = 0, failures = 0;
  bit rd_req = 0, rd_vld = 0;

  always @(posedge clk) rd_vld <= rd_req;

  always @(negedge clk)
    if (rd_vld) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_read rd2=%h required=none", d_rd);
      end else begin
        e = sb.pop_front();
        got = e.inst ? i_rd : d_rd;
        if (got !== e.exp) begin
          failures++;
          $display("FAIL %s got=%h required=%h", e.name, got, e.exp);
        end
      end
    end

  function automatic logic [31:0] ei(int imm, int rs1, int f3, int rd, int op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] er(int f7, int rs2, int rs1, int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] es(int imm, int rs2, int rs1, int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] eb(int imm, int rs2, int rs1, int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] eu(int imm, int rd, int op);
    return {imm[19:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] ej(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
  endfunction

  localparam logic [31:0] LOOP = 32'h0000006F;

  task automatic p(input logic [31:0] w);
    prog.push_back(w);
  endtask

  task automatic dwr(input bit inst, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] we);
    @(negedge clk);
    if (inst) begin i_a2 = addr; i_wd = data; i_we = we; end
    else begin d_a2 = addr; d_wd = data; d_we = we; end
    @(negedge clk);
    i_we = 0;
    d_we = 0;
  endtask

  task automatic rd(input bit inst, input logic [31:0] addr, input logic [31:0] exp, input string name);
    @(negedge clk);
    if (inst) i_a2 = addr; else d_a2 = addr;
    rd_req = 1;
    sb.push_back('{name, inst, exp});
    @(negedge clk);
    rd_req = 0;
  endtask

  task automatic hold();
    @(negedge clk);
    rst_n = 0;
    prog.delete();
  endtask

  task automatic boot(input int cycles);
    foreach (prog[i]) dwr(1, 32'(4 * i), prog[i], 4'hF);
    @(negedge clk);
    rst_n = 1;
    repeat (cycles) @(negedge clk);
  endtask

  int bf3[6] = '{0, 1, 4, 6, 5, 7};
  int brs[6] = '{2, 2, 5, 5, 5, 5};
  logic [31:0] bexp[6] = '{32'd2, 32'd1, 32'd1, 32'd2, 32'd2, 32'd1};

  initial begin
    // reset state: RD2 registers held at zero even after debug writes
    dwr(0, 0, 32'hDEADBEEF, 4'hF);
    dwr(1, 0, 32'hCAFEF00D, 4'hF);
    rd(0, 0, 32'h0, "rst_data_rd2");
    rd(1, 0, 32'h0, "rst_inst_rd2");

    hold();
    p(32'h00500093); p(32'h00102023); p(LOOP);
    boot(4);
    rd(0, 0, 32'h00000005, "addi_sw");
    rd(1, 0, 32'h00500093, "inst_rd2");
    rd(1, 8, LOOP, "inst_rd2_loop");

    hold();
    dwr(0, 8, 32'h0, 4'hF);
    p(eu(32'h12345, 2, 'h37)); p(ei('h678, 2, 0, 2, 'h13)); p(es(8, 2, 0, 2)); p(LOOP);
    boot(6);
    rd(0, 8, 32'h12345678, "lui_addi");

    for (int k = 0; k < 6; k++) begin
      hold();
      dwr(0, 12, 32'h0, 4'hF);
      p(ei(3, 0, 0, 1, 'h13)); p(ei(3, 0, 0, 2, 'h13)); p(ei(1, 0, 0, 3, 'h13));
      p(ei(2, 0, 0, 4, 'h13)); p(ei(-1, 0, 0, 5, 'h13));
      p(eb(12, brs[k], 1, bf3[k])); p(es(12, 3, 0, 2)); p(LOOP); p(es(12, 4, 0, 2)); p(LOOP);
      boot(12);
      rd(0, 12, bexp[k], $sformatf("branch_f3_%0d", bf3[k]));
    end

    hold();
    dwr(0, 16, 32'hFFFFFFFF, 4'hF);
    dwr(0, 24, 32'h0, 4'hF);
    p(ei(7, 0, 0, 0, 'h13)); p(es(16, 0, 0, 2));
    p(ei(9, 0, 0, 5, 'h13)); p(32'h00000073); p(er(1, 5, 5, 0, 5)); p(es(24, 5, 0, 2)); p(LOOP);
    boot(10);
    rd(0, 16, 32'h0, "x0_write");
    rd(0, 24, 32'd9, "unsupported_nop");

    dwr(0, 20, 32'h11223344, 4'hF);
    dwr(0, 20, 32'hAABBCCDD, 4'b0011);
    rd(0, 20, 32'h1122CCDD, "debug_lanes");
    rd(0, 32'h4000 + 20, 32'h1122CCDD, "debug_wrap");

    hold();
    p(ei(-8, 0, 0, 1, 'h13)); p(ei(3, 0, 0, 2, 'h13)); p(ei(35, 0, 0, 15, 'h13));
    p(er('h20, 2, 1, 0, 3)); p(er('h20, 2, 1, 5, 4)); p(er(0, 2, 1, 5, 5));
    p(er(0, 15, 2, 1, 6)); p(er(0, 2, 1, 2, 7)); p(er(0, 2, 1, 3, 8));
    p(ei('hFF, 1, 4, 9, 'h13)); p(ei('h401, 1, 5, 11, 'h13)); p(eu(1, 12, 'h17));
    p(ej(8, 13)); p(ei(0, 0, 0, 12, 'h13)); p(ei(73, 0, 0, 16, 'h13));
    p(ei(0, 16, 0, 14, 'h67)); p(ei(0, 0, 0, 14, 'h13)); p(ei(0, 0, 0, 14, 'h13));
    p(es(128, 3, 0, 2)); p(es(132, 4, 0, 2)); p(es(136, 5, 0, 2)); p(es(140, 6, 0, 2));
    p(es(144, 7, 0, 2)); p(es(148, 8, 0, 2)); p(es(152, 9, 0, 2)); p(es(156, 11, 0, 2));
    p(es(160, 12, 0, 2)); p(es(164, 13, 0, 2)); p(es(168, 14, 0, 2)); p(LOOP);
    boot(40);
    rd(0, 128, 32'hFFFFFFF5, "sub");
    rd(0, 132, 32'hFFFFFFFF, "sra");
    rd(0, 136, 32'h1FFFFFFF, "srl");
    rd(0, 140, 32'h00000018, "sll_mask");
    rd(0, 144, 32'h00000001, "slt");
    rd(0, 148, 32'h00000000, "sltu");
    rd(0, 152, 32'hFFFFFF07, "xori");
    rd(0, 156, 32'hFFFFFFFC, "srai");
    rd(0, 160, 32'h0000102C, "auipc");
    rd(0, 164, 32'h00000034, "jal_link");
    rd(0, 168, 32'h00000040, "jalr_link");

    hold();
    dwr(0, 40, 32'h0, 4'hF);
    p(ei(-1, 0, 0, 1, 'h13)); p(ei('h77, 0, 0, 2, 'h13)); p(ei('h77, 0, 0, 3, 'h13));
    p(es(41, 1, 0, 0)); p(ei(41, 0, 0, 2, 'h03)); p(ei(41, 0, 4, 3, 'h03));
    p(es(44, 2, 0, 2)); p(es(48, 3, 0, 2)); p(LOOP);
    boot(12);
`ifdef RV32_SUBWORD_MEM_EN
    rd(0, 40, 32'h0000FF00, "sb_word");
    rd(0, 44, 32'hFFFFFFFF, "lb");
    rd(0, 48, 32'h000000FF, "lbu");
`else
    rd(0, 40, 32'h00000000, "sb_word");
    rd(0, 44, 32'h00000077, "lb");
    rd(0, 48, 32'h00000077, "lbu");
`endif

    hold();
    dwr(0, 28, 32'h0, 4'hF);
    p(ei(9, 0, 0, 1, 'h13)); p(LOOP);
    boot(5);
    dwr(1, 8, es(28, 1, 0, 2), 4'hF);
    dwr(1, 12, LOOP, 4'hF);
    dwr(1, 4, 32'h00000013, 4'hF);
    repeat (5) @(negedge clk);
    rd(0, 28, 32'd9, "self_modify");

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
